// File: rtl/msg_stream_checker.sv
// msg_stream_checker
// Receive-side checker for the 8-bit ASCII text stream. Each valid input byte
// is compared against the expected message text fetched from the shared text
// ROM. The checker hunts for the first byte of the selected message, tracks the
// message byte by byte, counts complete messages and mismatches, and reports
// lock status.
//
// Build option:
//   MSG_CHECK_7BIT_EN  when defined, every compare ignores bit 7 so the
//                      checker works behind 7-bit terminal links.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   sel          message select (B when sel[1]^sel[0], A otherwise)
//   in_valid     in_byte holds a received character this cycle
//   in_byte      received character
//   clr_counts   synchronous clear of both counters (wins over increments)
//   exp_addr     ROM index of the expected byte
//   exp_sel_b    ROM bank select (registered message mode)
//   exp_byte     ROM data for exp_addr/exp_sel_b, same cycle
//   locked       a whole message matched since the last loss of sync
//   msg_done     one-cycle pulse after the last byte of a message matched
//   err_pulse    one-cycle pulse after a mismatching byte while tracking
//   msg_count    completed messages, wrapping
//   err_count    mismatches, saturating at all-ones
//   state_o      0 = HUNT, 1 = TRACK
module msg_stream_checker #(
  parameter int unsigned MSG_A_LEN = 126,
  parameter int unsigned MSG_B_LEN = 77,
  parameter int unsigned IDX_W     = 7,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  input  logic             clr_counts,
  output logic [IDX_W-1:0] exp_addr,
  output logic             exp_sel_b,
  input  logic [7:0]       exp_byte,
  output logic             locked,
  output logic             msg_done,
  output logic             err_pulse,
  output logic [CNT_W-1:0] msg_count,
  output logic [CNT_W-1:0] err_count,
  output logic             state_o
);

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_A  = IDX_W'(MSG_A_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_B  = IDX_W'(MSG_B_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mode_q, mode_d;
  logic             locked_q, locked_d;
  logic             msg_done_q, msg_done_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] msg_count_q, msg_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic sel_b_c;
  logic byte_match_c;
  logic last_idx_c;

  // Message B is selected by the odd-parity select codes.
  assign sel_b_c = sel[1] ^ sel[0];

`ifdef MSG_CHECK_7BIT_EN
  // Bit 7 is masked out of the difference so 7-bit links still match.
  assign byte_match_c = ((in_byte ^ exp_byte) & 8'h7F) == 8'h00;
`else
  assign byte_match_c = (in_byte == exp_byte);
`endif

  assign last_idx_c = (idx_q == (mode_q ? LAST_B : LAST_A));

  // State and datapath registers; mode tracks the select decode out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      idx_q       <= '0;
      mode_q      <= sel_b_c;
      locked_q    <= 1'b0;
      msg_done_q  <= 1'b0;
      err_pulse_q <= 1'b0;
      msg_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      locked_q    <= locked_d;
      msg_done_q  <= msg_done_d;
      err_pulse_q <= err_pulse_d;
      msg_count_q <= msg_count_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state logic: a select change overrides everything, then byte checking.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    locked_d    = locked_q;
    msg_done_d  = 1'b0;
    err_pulse_d = 1'b0;
    msg_count_d = msg_count_q;
    err_count_d = err_count_q;

    if (sel_b_c != mode_q) begin
      // Resync to the new message; the byte of this cycle is dropped.
      mode_d   = sel_b_c;
      state_d  = HUNT;
      idx_d    = '0;
      locked_d = 1'b0;
    end else if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          idx_d = '0;
          if (byte_match_c) begin
            idx_d   = IDX_ONE;
            state_d = TRACK;
          end
        end
        TRACK: begin
          if (byte_match_c) begin
            if (last_idx_c) begin
              // Wrap straight into the next message without a gap.
              idx_d       = '0;
              msg_done_d  = 1'b1;
              locked_d    = 1'b1;
              msg_count_d = msg_count_q + CNT_ONE;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end else begin
            // The bad byte is discarded, not re-tested as a message start.
            idx_d       = '0;
            state_d     = HUNT;
            locked_d    = 1'b0;
            err_pulse_d = 1'b1;
            if (err_count_q != CNT_MAX) begin
              err_count_d = err_count_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d = HUNT;
          idx_d   = '0;
        end
      endcase
    end

    if (clr_counts) begin
      msg_count_d = '0;
      err_count_d = '0;
    end
  end

  assign exp_addr  = idx_q;
  assign exp_sel_b = mode_q;
  assign locked    = locked_q;
  assign msg_done  = msg_done_q;
  assign err_pulse = err_pulse_q;
  assign msg_count = msg_count_q;
  assign err_count = err_count_q;
  assign state_o   = state_q;

endmodule

// File: doc/msg_stream_checker.md
Name: msg_stream_checker

Overview:
- Receive side of the 8-bit ASCII text-stream output: consumes one byte per valid cycle and checks it against the expected message text.
- Expected text is read from the shared text ROM through an address/data port.
- Locks onto message boundaries, counts complete messages and byte errors, and flags lock status for the board LEDs/bidirectional pins.
- Message selection uses the same 2-bit select encoding as the transmitter: 00/11 select message A, 01/10 select message B.

Parameters:
- MSG_A_LEN, 126, byte count of message A (ROM indices 0..MSG_A_LEN-1)
- MSG_B_LEN, 77, byte count of message B (ROM indices 0..MSG_B_LEN-1)
- IDX_W, 7, width of the byte index; must satisfy 2^IDX_W >= max(MSG_A_LEN, MSG_B_LEN)
- CNT_W, 8, width of msg_count and err_count

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- sel  in  2  message select; mode B = sel[1]^sel[0], mode A otherwise
- in_valid  in  1  in_byte carries a received character this cycle
- in_byte  in  8  received character
- clr_counts  in  1  synchronous clear of msg_count and err_count
- exp_addr  out  IDX_W  ROM index of the expected byte (= idx register)
- exp_sel_b  out  1  ROM bank select (= registered mode)
- exp_byte  in  8  expected byte; combinational ROM output for exp_addr/exp_sel_b, same cycle
- locked  out  1  a full message matched since the last loss of sync
- msg_done  out  1  one-cycle pulse when the last byte of a message matches
- err_pulse  out  1  one-cycle pulse on a mismatching byte while TRACK
- msg_count  out  CNT_W  completed messages, wrapping
- err_count  out  CNT_W  mismatches, saturating at all-ones
- state_o  out  1  0 = HUNT, 1 = TRACK

Behaviour:
- Reset (async): state HUNT, idx 0, mode_q = current sel decode, locked 0, msg_done 0, err_pulse 0, both counts 0.
- len = MSG_B_LEN if mode_q else MSG_A_LEN. All outputs are registered except exp_addr and exp_sel_b, which are register-driven.
- Mode change: when the decode of sel differs from mode_q, on the next edge:
  - mode_q updates, state goes to HUNT, idx goes to 0, locked clears.
  - Any in_valid byte in that cycle is ignored; counts are kept.
- HUNT:
  - idx is held at 0.
  - On in_valid with in_byte==exp_byte: idx becomes 1 and state goes to TRACK.
  - Otherwise stay in HUNT. No error is counted in HUNT.
- TRACK, on in_valid:
  - Match with idx==len-1: msg_done=1, msg_count+1, locked=1, idx becomes 0, stay in TRACK. Back-to-back messages are tracked without a gap.
  - Match with idx<len-1: idx+1.
  - Mismatch: err_pulse=1, err_count+1 (saturating), locked=0, idx becomes 0, state goes to HUNT. The mismatching byte is discarded and is not re-tested as a message start.
- in_valid low: no state change; pulses are 0.
- msg_done and err_pulse are high for exactly the cycle after the qualifying byte.
- clr_counts: both counts go to 0 next cycle. It wins over a simultaneous increment; the pulses still fire.
- idx never exceeds len-1. A mode change while idx exceeds the new len is handled by the forced return to 0.
- Latency: one cycle from in_byte to msg_done/err_pulse/locked.

Optional Feature:
- Macro: MSG_CHECK_7BIT_EN.
- Defined: all compares (HUNT and TRACK) use bits [6:0] only, so 0xA1 matches 0x21 and 0xE1 matches 0x61. This supports 7-bit terminal links.
- Undefined: full 8-bit compare.

Test Plan:
- Reset, sel=00, ROM A byte0=0xA1, byte1=0x47; feed all 126 message A bytes -> state TRACK after byte 0; msg_done pulses once one cycle after byte 125; msg_count=1, locked=1, err_count=0.
- sel=01; feed 0x50, 0x50, 0x72 then 0x00 -> err_pulse once, err_count=1, state HUNT, idx=0, locked=0.
- Lock message B (77 bytes), then change sel to 11 mid-message at idx 30 -> next cycle HUNT, exp_addr=0, exp_sel_b=0, locked=0, msg_count unchanged.
- In HUNT, feed 10 bytes none equal to 0xA1 -> no err_pulse, err_count unchanged. Then send 0xA1 -> TRACK, exp_addr=1.
- Force 260 mismatches (each preceded by 0xA1) -> err_count saturates at 0xFF. clr_counts asserted in the same cycle as a mismatch -> err_count=0, err_pulse=1.
- Built with MSG_CHECK_7BIT_EN, sel=00, send 0x21 as first byte -> accepted, TRACK. Built without the macro -> stays in HUNT.
